node_input_sequencer: RTL and testbench
=======================================

NODE_INPUT_SEQUENCER -- requirements
Module: node_input_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of data and weights (IEEE-754 single).
REQ-002 SHALL have parameter NUM_INPUTS, default 32, number of data inputs per node evaluation, excluding bias.
REQ-003 SHALL have parameter BIAS_ONE, default 32'h3F800000, data word paired with the bias weight (1.0).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-high reset (asserted = 1).
REQ-006 SHALL have port i_valid  input  1  input data beat present.
REQ-007 SHALL have port i_data  input  DATA_WIDTH  input vector element.
REQ-008 SHALL have port o_ready  output  1  block accepts i_valid beats.
REQ-009 SHALL have port i_w_we  input  1  weight write strobe.
REQ-010 SHALL have port i_w_addr  input  6  weight index, 0..NUM_INPUTS-1 data weights, NUM_INPUTS = bias weight.
REQ-011 SHALL have port i_w_data  input  DATA_WIDTH  weight value.
REQ-012 SHALL have port o_valid  output  1  product-pair beat to downstream node multiplier.
REQ-013 SHALL have port o_data  output  DATA_WIDTH  data operand.
REQ-014 SHALL have port o_weight  output  DATA_WIDTH  weight operand.
REQ-015 SHALL have port o_last  output  1  marks final (bias) beat of a burst.

Function
REQ-016 SHALL implement states LOAD and STREAM; reset enters LOAD.
REQ-017 LOAD: o_ready = 1; each cycle with i_valid = 1 stores i_data at data index = load counter, counter increments.
REQ-018 LOAD -> STREAM on the cycle the beat with load counter = NUM_INPUTS-1 is accepted; load counter clears.
REQ-019 STREAM: o_ready = 0; i_valid beats ignored, not stored, not counted.
REQ-020 STREAM SHALL emit exactly NUM_INPUTS+1 beats on consecutive cycles, no bubbles, o_valid = 1 each cycle.
REQ-021 First o_valid SHALL occur the cycle after the last data beat is accepted (1-cycle latency).
REQ-022 Beat k (0..NUM_INPUTS-1): o_data = stored data[k], o_weight = weight[k].
REQ-023 Beat NUM_INPUTS: o_data = BIAS_ONE, o_weight = weight[NUM_INPUTS], o_last = 1.
REQ-024 STREAM -> LOAD after the bias beat; o_ready = 1 and o_valid = 0 the following cycle.
REQ-025 Outside beats o_valid = 0, o_last = 0; o_data/o_weight hold last values.
REQ-026 Weight writes SHALL be accepted in any state; i_w_addr > NUM_INPUTS ignored.
REQ-027 Write to the index being emitted in the same cycle: emitted beat carries old value; new value visible from next cycle.
REQ-028 No arithmetic on data/weights; words pass bit-exact.

Reset
REQ-029 Reset values: o_valid 0, o_last 0, o_data 0, o_weight 0, o_ready 1 (the cycle after rst_n deasserts), state LOAD, counters 0.
REQ-030 Reset mid-LOAD or mid-STREAM SHALL abort: partial vector discarded, no further beats of the aborted burst.
REQ-031 Weight storage and data storage SHALL NOT be cleared by reset.

Structure
REQ-032 Shared package node_pkg SHALL hold FP32_ONE constant, default NUM_INPUTS, and state enum {LOAD, STREAM}.
REQ-033 Weight storage SHALL be one sub-module node_weight_bank (NUM_INPUTS+1 x DATA_WIDTH, 1 write port, 1 registered read port).
REQ-034 Implementation target 120-400 lines of RTL.

Verification
REQ-035 Reset, write weights w[k]=k+1 (as raw hex), stream data d[k]=32'h40000000 for 32 cycles -> 33 consecutive o_valid beats, beat 32 o_data=32'h3F800000, o_weight=33, o_last=1 only there.
REQ-036 i_valid toggled 1/0 during LOAD (64 cycles) -> exactly 32 stored, first o_valid one cycle after 32nd accepted beat.
REQ-037 i_valid held 1 during STREAM with data 32'hDEADBEEF -> ignored; next burst contains only beats sent after o_ready returns.
REQ-038 i_w_we to addr 5 with 32'h3F000000 in the cycle beat 5 emits -> beat 5 shows old weight; next burst shows 32'h3F000000; write to addr 40 -> no change.
REQ-039 rst_n pulsed at beat 10 of STREAM -> o_valid 0 next cycle, o_ready 1, fresh 32-beat load required; weights retained.
REQ-040 Two back-to-back vectors (i_valid asserted as soon as o_ready rises) -> two 33-beat bursts separated by exactly 32 LOAD cycles.

Source files
------------

// File: rtl/node_pkg.sv
// Shared constants and state encoding for the node input sequencer.
package node_pkg;

  localparam logic [31:0] FP32_ONE = 32'h3F800000;
  localparam int DEFAULT_NUM_INPUTS = 32;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/node_weight_bank.sv
// Weight storage: NUM_INPUTS data weights plus one bias weight, one write
// port and one registered read port whose output holds when not enabled.
module node_weight_bank
  import node_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
  localparam int AW = $clog2(NUM_INPUTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [5:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_INPUTS+1];

  // Storage is deliberately not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) <= NUM_INPUTS)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/node_input_sequencer.sv
// Collects NUM_INPUTS data words, then streams data/weight pairs followed by
// a bias pair (BIAS_ONE, bias weight) to the downstream node multiplier.
module node_input_sequencer
  import node_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_INPUTS = DEFAULT_NUM_INPUTS,
  parameter logic [DATA_WIDTH-1:0] BIAS_ONE   = FP32_ONE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_w_we,
  input  logic [5:0]            i_w_addr,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [DATA_WIDTH-1:0] o_weight,
  output logic                  o_last
);

  localparam int AW  = $clog2(NUM_INPUTS + 1);
  localparam int CW  = $clog2(NUM_INPUTS + 2);
  localparam int DIW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(NUM_INPUTS - 1);
  localparam logic [CW-1:0] BIAS_IDX  = CW'(NUM_INPUTS);
  localparam logic [CW-1:0] DRAIN_IDX = CW'(NUM_INPUTS + 1);

  state_t                state;
  logic [CW-1:0]         load_cnt;
  logic [CW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] data_mem [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  accept;
  logic                  last_accept;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;

  assign o_ready     = (state == LOAD);
  assign accept      = (state == LOAD) && i_valid && !rst_n;
  assign last_accept = accept && (load_cnt == LAST_DATA);

  // Beat 0 is issued on the edge that accepts the final data word, so the
  // weight read for index 0 is launched from LOAD.
  assign rd_en   = last_accept || ((state == STREAM) && (beat_cnt <= BIAS_IDX));
  assign rd_addr = (state == LOAD) ? '0 : AW'(beat_cnt);

  always_comb begin
    beat_data = BIAS_ONE;
    if (state == LOAD) begin
      beat_data = (load_cnt == '0) ? i_data : data_mem[DIW'(0)];
    end else if (beat_cnt < BIAS_IDX) begin
      beat_data = data_mem[beat_cnt[DIW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[load_cnt[DIW-1:0]] <= i_data;
    end
  end

  // STREAM stays one cycle past the last issue so o_ready rises only after
  // the bias beat has been presented.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= LOAD;
      load_cnt <= '0;
      beat_cnt <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_data   <= '0;
    end else begin
      case (state)
        LOAD: begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          if (i_valid) begin
            if (load_cnt == LAST_DATA) begin
              state    <= STREAM;
              load_cnt <= '0;
              beat_cnt <= CW'(1);
              o_valid  <= 1'b1;
              o_data   <= beat_data;
            end else begin
              load_cnt <= load_cnt + CW'(1);
            end
          end
        end
        STREAM: begin
          if (beat_cnt == DRAIN_IDX) begin
            state    <= LOAD;
            beat_cnt <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
          end else begin
            o_valid  <= 1'b1;
            o_last   <= (beat_cnt == BIAS_IDX);
            o_data   <= beat_data;
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  node_weight_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_weight_bank (
    .clk   (clk),
    .rst   (rst_n),
    .we    (i_w_we),
    .waddr (i_w_addr),
    .wdata (i_w_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (o_weight)
  );

endmodule

// File: tb/tb_node_input_sequencer.sv
// Directed bench for node_input_sequencer: load/stream bursts, ignored beats,
// weight write collisions, reset aborts and back-to-back vectors.
module tb_node_input_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        o_ready;
  logic        i_w_we;
  logic [5:0]  i_w_addr;
  logic [31:0] i_w_data;
  logic        o_valid;
  logic [31:0] o_data;
  logic [31:0] o_weight;
  logic        o_last;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  logic [31:0] vec     [32];
  logic [31:0] w_model [33];

  logic [31:0] obs_data   [40];
  logic [31:0] obs_weight [40];
  logic        obs_last   [40];
  logic        obs_ready  [40];
  int          obs_n;
  logic        obs_first;
  logic        obs_ready_after;
  logic        obs_valid_after;
  int          obs_start_cyc;
  int          obs_end_cyc;

  node_input_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .i_w_we   (i_w_we),
    .i_w_addr (i_w_addr),
    .i_w_data (i_w_data),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_weight (o_weight),
    .o_last   (o_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic write_weight(input logic [5:0] addr, input logic [31:0] val);
    i_w_we   = 1'b1;
    i_w_addr = addr;
    i_w_data = val;
    @(negedge clk);
    i_w_we = 1'b0;
    if (addr <= 6'd32) w_model[addr] = val;
  endtask

  // Called at a negedge; returns at the negedge after the last accepted beat.
  task automatic send_vector(input int count, input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < count) begin
      if (toggle && (cyc % 2 == 1)) begin
        i_valid = 1'b0;
      end else begin
        i_valid = 1'b1;
        i_data  = vec[idx];
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic collect_burst(input bit hold, input int wr_beat,
                               input logic [5:0] wr_addr, input logic [31:0] wr_val);
    obs_n         = 0;
    obs_first     = o_valid;
    obs_start_cyc = cyc_cnt;
    while ((o_valid === 1'b1) && (obs_n < 40)) begin
      obs_data[obs_n]   = o_data;
      obs_weight[obs_n] = o_weight;
      obs_last[obs_n]   = o_last;
      obs_ready[obs_n]  = o_ready;
      i_valid = hold;
      i_data  = 32'hDEADBEEF;
      if (obs_n == wr_beat) begin
        i_w_we   = 1'b1;
        i_w_addr = wr_addr;
        i_w_data = wr_val;
      end else begin
        i_w_we = 1'b0;
      end
      obs_n++;
      @(negedge clk);
    end
    i_valid         = 1'b0;
    i_w_we          = 1'b0;
    obs_ready_after = o_ready;
    obs_valid_after = o_valid;
    obs_end_cyc     = cyc_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; i_valid = 1'b0; i_data = '0;
    i_w_we = 1'b0; i_w_addr = '0; i_w_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset o_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset o_last: got %b expected 0", o_last); end
    n_cmp++; if (o_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset o_data: got %h expected 0", o_data); end
    n_cmp++; if (o_weight !== 32'h0) begin n_fail++; $display("[TB] FAIL reset o_weight: got %h expected 0", o_weight); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset o_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_basic_stream();
    for (int k = 0; k < 33; k++) write_weight(6'(k), 32'(k + 1));
    for (int k = 0; k < 32; k++) vec[k] = 32'h40000000;
    send_vector(32, 1'b0);
    collect_burst(1'b0, -1, '0, '0);
    n_cmp++; if (obs_first !== 1'b1) begin n_fail++; $display("[TB] FAIL basic latency: got o_valid %b expected 1", obs_first); end
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL basic beat count: got %0d expected 33", obs_n); end
    for (int k = 0; k < 33 && k < obs_n; k++) begin
      logic [31:0] exp_d;
      exp_d = (k < 32) ? 32'h40000000 : 32'h3F800000;
      n_cmp++; if (obs_data[k] !== exp_d) begin n_fail++; $display("[TB] FAIL basic beat%0d data: got %h expected %h", k, obs_data[k], exp_d); end
      n_cmp++; if (obs_weight[k] !== 32'(k + 1)) begin n_fail++; $display("[TB] FAIL basic beat%0d weight: got %h expected %h", k, obs_weight[k], 32'(k + 1)); end
      n_cmp++; if (obs_last[k] !== (k == 32)) begin n_fail++; $display("[TB] FAIL basic beat%0d last: got %b expected %b", k, obs_last[k], (k == 32)); end
    end
    n_cmp++; if (obs_ready_after !== 1'b1) begin n_fail++; $display("[TB] FAIL basic ready after: got %b expected 1", obs_ready_after); end
    n_cmp++; if (obs_valid_after !== 1'b0) begin n_fail++; $display("[TB] FAIL basic valid after: got %b expected 0", obs_valid_after); end
  endtask

  task automatic test_load_toggle();
    for (int k = 0; k < 32; k++) vec[k] = 32'h41000000 + 32'(k);
    send_vector(32, 1'b1);
    collect_burst(1'b0, -1, '0, '0);
    n_cmp++; if (obs_first !== 1'b1) begin n_fail++; $display("[TB] FAIL toggle latency: got o_valid %b expected 1", obs_first); end
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL toggle beat count: got %0d expected 33", obs_n); end
    for (int k = 0; k < 32 && k < obs_n; k++) begin
      n_cmp++; if (obs_data[k] !== vec[k]) begin n_fail++; $display("[TB] FAIL toggle beat%0d data: got %h expected %h", k, obs_data[k], vec[k]); end
    end
  endtask

  task automatic test_stream_ignore();
    for (int k = 0; k < 32; k++) vec[k] = 32'h10000000 + 32'(k);
    send_vector(32, 1'b0);
    collect_burst(1'b1, -1, '0, '0);
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL ignore first count: got %0d expected 33", obs_n); end
    for (int k = 0; k < 33 && k < obs_n; k++) begin
      n_cmp++; if (obs_ready[k] !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore beat%0d ready: got %b expected 0", k, obs_ready[k]); end
    end
    for (int k = 0; k < 32; k++) vec[k] = 32'h20000000 + 32'(k);
    send_vector(32, 1'b0);
    collect_burst(1'b0, -1, '0, '0);
    n_cmp++; if (obs_first !== 1'b1) begin n_fail++; $display("[TB] FAIL ignore second latency: got o_valid %b expected 1", obs_first); end
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL ignore second count: got %0d expected 33", obs_n); end
    for (int k = 0; k < 33 && k < obs_n; k++) begin
      logic [31:0] exp_d;
      exp_d = (k < 32) ? vec[k] : 32'h3F800000;
      n_cmp++; if (obs_data[k] !== exp_d) begin n_fail++; $display("[TB] FAIL ignore beat%0d data: got %h expected %h", k, obs_data[k], exp_d); end
    end
  endtask

  task automatic test_weight_collision();
    logic [31:0] old_w5;
    old_w5 = w_model[5];
    for (int k = 0; k < 32; k++) vec[k] = 32'h42000000 + 32'(k);
    send_vector(32, 1'b0);
    collect_burst(1'b0, 5, 6'd5, 32'h3F000000);
    w_model[5] = 32'h3F000000;
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL collision count: got %0d expected 33", obs_n); end
    n_cmp++; if (obs_weight[5] !== old_w5) begin n_fail++; $display("[TB] FAIL collision beat5 old weight: got %h expected %h", obs_weight[5], old_w5); end
    n_cmp++; if (obs_weight[6] !== w_model[6]) begin n_fail++; $display("[TB] FAIL collision beat6 weight: got %h expected %h", obs_weight[6], w_model[6]); end
    write_weight(6'd40, 32'h12345678);
    send_vector(32, 1'b0);
    collect_burst(1'b0, -1, '0, '0);
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL collision next count: got %0d expected 33", obs_n); end
    for (int k = 0; k < 33 && k < obs_n; k++) begin
      n_cmp++; if (obs_weight[k] !== w_model[k]) begin n_fail++; $display("[TB] FAIL collision next beat%0d weight: got %h expected %h", k, obs_weight[k], w_model[k]); end
    end
  endtask

  task automatic test_reset_abort();
    for (int k = 0; k < 32; k++) vec[k] = 32'h30000000 + 32'(k);
    send_vector(10, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL load abort ready: got %b expected 1", o_ready); end
    for (int k = 0; k < 32; k++) vec[k] = 32'h31000000 + 32'(k);
    send_vector(32, 1'b0);
    collect_burst(1'b0, -1, '0, '0);
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL load abort count: got %0d expected 33", obs_n); end
    for (int k = 0; k < 32 && k < obs_n; k++) begin
      n_cmp++; if (obs_data[k] !== vec[k]) begin n_fail++; $display("[TB] FAIL load abort beat%0d data: got %h expected %h", k, obs_data[k], vec[k]); end
    end
    for (int k = 0; k < 32; k++) vec[k] = 32'h32000000 + 32'(k);
    send_vector(32, 1'b0);
    for (int k = 0; k < 10; k++) @(negedge clk);
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stream abort beat10 valid: got %b expected 1", o_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream abort valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream abort ready: got %b expected 1", o_ready); end
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream abort no resume: got %b expected 0", o_valid); end
    for (int k = 0; k < 32; k++) vec[k] = 32'h33000000 + 32'(k);
    send_vector(31, 1'b0);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream abort early burst: got %b expected 0", o_valid); end
    i_valid = 1'b1;
    i_data  = vec[31];
    @(negedge clk);
    i_valid = 1'b0;
    collect_burst(1'b0, -1, '0, '0);
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL stream abort count: got %0d expected 33", obs_n); end
    for (int k = 0; k < 33 && k < obs_n; k++) begin
      logic [31:0] exp_d;
      exp_d = (k < 32) ? vec[k] : 32'h3F800000;
      n_cmp++; if (obs_data[k] !== exp_d) begin n_fail++; $display("[TB] FAIL stream abort beat%0d data: got %h expected %h", k, obs_data[k], exp_d); end
      n_cmp++; if (obs_weight[k] !== w_model[k]) begin n_fail++; $display("[TB] FAIL stream abort beat%0d weight: got %h expected %h", k, obs_weight[k], w_model[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int end_a;
    int n_a;
    for (int k = 0; k < 32; k++) vec[k] = 32'h50000000 + 32'(k);
    send_vector(32, 1'b0);
    collect_burst(1'b0, -1, '0, '0);
    n_a   = obs_n;
    end_a = obs_end_cyc;
    for (int k = 0; k < 32; k++) vec[k] = 32'h60000000 + 32'(k);
    send_vector(32, 1'b0);
    collect_burst(1'b0, -1, '0, '0);
    n_cmp++; if (n_a != 33) begin n_fail++; $display("[TB] FAIL b2b first count: got %0d expected 33", n_a); end
    n_cmp++; if (obs_n != 33) begin n_fail++; $display("[TB] FAIL b2b second count: got %0d expected 33", obs_n); end
    n_cmp++; if (obs_start_cyc - end_a != 32) begin n_fail++; $display("[TB] FAIL b2b gap: got %0d expected 32", obs_start_cyc - end_a); end
    n_cmp++; if (obs_data[0] !== 32'h60000000) begin n_fail++; $display("[TB] FAIL b2b beat0 data: got %h expected 60000000", obs_data[0]); end
    n_cmp++; if (obs_data[31] !== 32'h6000001F) begin n_fail++; $display("[TB] FAIL b2b beat31 data: got %h expected 6000001f", obs_data[31]); end
    n_cmp++; if (obs_last[32] !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b bias last: got %b expected 1", obs_last[32]); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_load_toggle();
    test_stream_ignore();
    test_weight_collision();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
